fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
Read-side controller for the team's synchronous FIFO. It is the pop-side counterpart to the write-pointer counter. It compares the write pointer against its own read pointer and issues reads to the FIFO storage array, which has a 1-cycle read latency. Returned words go into a 2-entry output buffer and are presented on a valid/ready stream with first-word-fall-through behaviour, and the stream sustains one word per cycle. The block also exports the read pointer so the write side can compute its full flag.

Parameters:
DATA_WIDTH, 8, width of each FIFO word
ADDR_WIDTH, 4, storage address width; depth = 2**ADDR_WIDTH

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_ptr  input  ADDR_WIDTH+1  write pointer from write side; MSB is the wrap bit
rd_ptr  output  ADDR_WIDTH+1  read pointer; MSB is the wrap bit
mem_rd_en  output  1  storage read strobe
mem_rd_addr  output  ADDR_WIDTH  storage read address = rd_ptr[ADDR_WIDTH-1:0]
mem_rd_data  input  DATA_WIDTH  storage data, valid the cycle after mem_rd_en
out_data  output  DATA_WIDTH  head-of-stream word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data
empty  output  1  no unconsumed word anywhere in FIFO or controller
fill_level  output  ADDR_WIDTH+2  total unconsumed words
overflow_err  output  1  sticky: pointer distance exceeded depth

Behaviour:
- Reset: when reset=1 at a rising edge, the following values apply.
  - rd_ptr=0, buffer count=0, in-flight=0.
  - out_valid=0, out_data=0, empty=1, fill_level=0, overflow_err=0.
  - mem_rd_en is forced 0 while reset is high.
- Reset mid-operation discards buffered and in-flight words. The write side is reset by the same signal.
- Definitions:
  - mem_level = (wr_ptr - rd_ptr) mod 2**(ADDR_WIDTH+1).
  - avail = (mem_level != 0).
  - pop = out_valid & out_ready.
  - buf_cnt ∈ {0,1,2}.
  - inflight ∈ {0,1} is a read issued the previous cycle.
- Read issue: mem_rd_en = avail & (buf_cnt + inflight - pop < 2).
  - mem_rd_en is combinational from registered state, wr_ptr and out_ready.
  - When mem_rd_en=1, rd_ptr increments by 1 at the next edge and wraps naturally on ADDR_WIDTH+1 bits. rd_ptr changes on no other occasion.
- Return: inflight=1 means mem_rd_data is captured this edge into the output buffer tail.
  - Capture and pop may occur in the same cycle.
  - buf_cnt_next = buf_cnt + inflight - pop.
  - The buffer never overflows, by the credit rule.
- Output: out_valid = (buf_cnt != 0); out_data = head entry, which is registered.
  - out_data is held stable while out_valid & !out_ready.
  - Word order is strictly FIFO order.
- Latency, assuming an idle controller with the buffer empty:
  - wr_ptr advances, visible at cycle N.
  - mem_rd_en=1 at cycle N.
  - Data is captured at edge N+1.
  - out_valid=1 at cycle N+2.
- Throughput: with out_ready held at 1 and avail continuous, one word per cycle with no bubbles.
- Backpressure: with out_ready=0, at most 2 words are drawn from storage (buf_cnt=2, inflight=0), then mem_rd_en stays 0.
- empty = !avail & (buf_cnt==0) & !inflight.
- fill_level = mem_level + buf_cnt + inflight, registered-state based.
- Write-side full logic uses rd_ptr directly, since buffered words have already freed storage slots.
- Error: if mem_level > 2**ADDR_WIDTH, overflow_err is set at the next edge and holds until reset. Otherwise the block keeps operating unchanged.
- wr_ptr pointer-equal with different wrap bits means the FIFO is full, not empty. In that case mem_level = 2**ADDR_WIDTH and avail=1.

Test Plan:
- Reset with wr_ptr=0 -> rd_ptr=0, out_valid=0, empty=1, fill_level=0, mem_rd_en=0 for all cycles while reset=1.
- Single word: wr_ptr 0->1 at cycle N, out_ready=1 -> mem_rd_en=1 with addr 0 at N; out_valid=1 with stored data at N+2; rd_ptr=1; empty=1 again after pop.
- Streaming: 16 words 0x00..0x0F preloaded (wr_ptr=16, MSB set), out_ready=1 -> out_valid continuous for 16 cycles, data 0x00..0x0F in order, rd_ptr wraps to 0b10000 then equals wr_ptr, and out_valid drops afterwards.
- Backpressure: 5 words present, out_ready=0 -> exactly 2 reads issued, fill_level=5, out_data stable. When out_ready is raised, all 5 words are delivered in order on consecutive cycles.
- Simultaneous capture and pop: buf_cnt=1, inflight=1, out_ready=1 -> buf_cnt stays 1, a new read is issued the same cycle, and no word is lost or duplicated.
- Overflow: force wr_ptr=17 with rd_ptr=0 -> overflow_err=1 next cycle, and it stays 1 until reset is asserted.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous FIFO: issues storage reads against the write pointer
// and presents returned words on a first-word-fall-through valid/ready stream.
module fifo_read_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] fill_level,
  output logic                  overflow_err
);

  localparam logic [ADDR_WIDTH:0] DepthLevel = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  overflow_q, overflow_d;

  logic [ADDR_WIDTH:0]   mem_level;
  logic                  avail;
  logic                  pop;
  logic [2:0]            credit;

  // Wrap bit makes pointer-equal-with-different-MSB read as a full level.
  assign mem_level = wr_ptr - rd_ptr_q;
  assign avail     = (mem_level != '0);
  assign out_valid = (buf_cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;

  // Words held or returning after this cycle; a new read is allowed only if it still fits.
  assign credit    = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_rd_en = ~reset & avail & (credit < 3'd2);

  assign mem_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr       = rd_ptr_q;
  assign out_data     = head_q;
  assign overflow_err = overflow_q;
  assign empty        = ~avail & (buf_cnt_q == 2'd0) & ~inflight_q;
  assign fill_level   = {1'b0, mem_level}
                      + {{ADDR_WIDTH{1'b0}}, buf_cnt_q}
                      + {{(ADDR_WIDTH + 1){1'b0}}, inflight_q};

  always_comb begin
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, mem_rd_en};
    buf_cnt_d  = credit[1:0];
    overflow_d = overflow_q | (mem_level > DepthLevel);
    head_d     = head_q;
    tail_d     = tail_q;
    case ({pop, inflight_q})
      2'b10: begin
        head_d = tail_q;
      end
      2'b01: begin
        if (buf_cnt_q == 2'd0) begin
          head_d = mem_rd_data;
        end else begin
          tail_d = mem_rd_data;
        end
      end
      2'b11: begin
        // Capture and pop together: returning word lands behind whatever remains.
        if (buf_cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = mem_rd_data;
        end else begin
          head_d = mem_rd_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= mem_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed latency/throughput/backpressure/overflow cases, then
// randomized traffic checked against a word-queue model of the FIFO contents.
module tb_fifo_read_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clock;
  logic          reset;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW+1:0] fill_level;
  logic          overflow_err;

  fifo_read_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .empty       (empty),
    .fill_level  (fill_level),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Storage array with 1-cycle read latency.
  logic [DW-1:0] mem [16];
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  int            reads;
  int            pops;
  logic          stall;
  logic [DW-1:0] stall_data;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wr_ptr = '0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    reads = 0;
    pops = 0;
    stall = 1'b0;
  endtask

  task automatic rand_cycle(input int wprob, input int rprob, input bit do_rst);
    logic [AW:0] lvl;
    int          outstanding;
    int          stored;
    logic        pop;
    @(negedge clock);
    if (do_rst) begin
      reset = 1'b1;
      wr_ptr = '0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_rd_en", mem_rd_en, 1'b0);
      exp_q.delete();
      reads = 0;
      pops = 0;
      stall = 1'b0;
      return;
    end
    reset = 1'b0;
    lvl = wr_ptr - rd_ptr;
    if ($urandom_range(0, 99) < wprob && lvl < 16) begin
      mem[wr_ptr[AW-1:0]] = DW'($urandom);
      exp_q.push_back(mem[wr_ptr[AW-1:0]]);
      wr_ptr = wr_ptr + 1'b1;
    end
    out_ready = ($urandom_range(0, 99) < rprob);
    #1;
    outstanding = reads - pops;
    stored = exp_q.size() - outstanding;
    pop = out_valid & out_ready;
    check_eq("fill", fill_level, exp_q.size());
    check_eq("empty", empty, exp_q.size() == 0);
    check_eq("addr", mem_rd_addr, rd_ptr[AW-1:0]);
    check_eq("rdptr", rd_ptr, reads % 32);
    check_eq("ovf", overflow_err, 1'b0);
    check_eq("rd_en", mem_rd_en, (stored > 0) && (outstanding - int'(pop) < 2));
    if (stall) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_data", out_data, stall_data);
    end
    if (pop) begin
      check_eq("pop_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        check_eq("data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      pops++;
    end
    if (mem_rd_en) reads++;
    stall = out_valid & ~out_ready;
    stall_data = out_data;
  endtask

  initial begin
    int rd_cnt;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1;
    wr_ptr = '0;
    out_ready = 1'b0;

    // Reset state, with mem_rd_en held low even when the write pointer moves.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check_eq("rst_rdptr", rd_ptr, 0);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_empty", empty, 1'b1);
      check_eq("rst_fill", fill_level, 0);
      check_eq("rst_ovf", overflow_err, 1'b0);
      check_eq("rst_rd_en", mem_rd_en, 1'b0);
    end
    @(negedge clock);
    wr_ptr = 5'd5;
    #1;
    check_eq("rst_rd_en_wr", mem_rd_en, 1'b0);
    @(negedge clock);
    wr_ptr = '0;
    reset = 1'b0;

    // Single word latency.
    mem[0] = 8'hA5;
    @(negedge clock);
    wr_ptr = 5'd1;
    out_ready = 1'b1;
    #1;
    check_eq("sw_rd_en", mem_rd_en, 1'b1);
    check_eq("sw_addr", mem_rd_addr, 0);
    check_eq("sw_valid0", out_valid, 1'b0);
    check_eq("sw_fill", fill_level, 1);
    @(negedge clock);
    #1;
    check_eq("sw_valid1", out_valid, 1'b0);
    check_eq("sw_rdptr", rd_ptr, 1);
    check_eq("sw_empty1", empty, 1'b0);
    @(negedge clock);
    #1;
    check_eq("sw_valid2", out_valid, 1'b1);
    check_eq("sw_data", out_data, 8'hA5);
    @(negedge clock);
    #1;
    check_eq("sw_valid3", out_valid, 1'b0);
    check_eq("sw_empty3", empty, 1'b1);

    // Streaming a full FIFO: no bubbles, strict order, pointer wrap.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    wr_ptr = 5'd16;
    out_ready = 1'b1;
    #1;
    check_eq("st_fill", fill_level, 16);
    check_eq("st_rd_en", mem_rd_en, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      #1;
      if (k >= 2 && k <= 17) begin
        check_eq("st_valid", out_valid, 1'b1);
        check_eq("st_data", out_data, k - 2);
      end else if (k == 18) begin
        check_eq("st_valid_end", out_valid, 1'b0);
        check_eq("st_rdptr", rd_ptr, 16);
        check_eq("st_empty", empty, 1'b1);
      end
    end

    // Backpressure: only two words drawn, head held, then back-to-back delivery.
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = DW'(8'h30 + i);
    wr_ptr = 5'd5;
    rd_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      if (mem_rd_en) rd_cnt++;
      check_eq("bp_fill", fill_level, 5);
      if (k >= 2) begin
        check_eq("bp_valid", out_valid, 1'b1);
        check_eq("bp_hold", out_data, 8'h30);
      end
    end
    check_eq("bp_reads", rd_cnt, 2);
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      check_eq("bp_valid_drain", out_valid, 1'b1);
      check_eq("bp_data", out_data, 8'h30 + j);
    end
    @(negedge clock);
    #1;
    check_eq("bp_done", out_valid, 1'b0);

    // Overflow is sticky until reset.
    do_reset();
    wr_ptr = 5'd17;
    #1;
    check_eq("ovf_pre", overflow_err, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      check_eq("ovf_set", overflow_err, 1'b1);
    end
    @(negedge clock);
    reset = 1'b1;
    wr_ptr = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("ovf_clr", overflow_err, 1'b0);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 1800; c++) begin
      int seg;
      seg = (c / 300) % 3;
      rand_cycle(seg == 0 ? 30 : (seg == 1 ? 70 : 95),
                 seg == 0 ? 50 : (seg == 1 ? 90 : 20), c == 900);
    end
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) rand_cycle(0, 100, 1'b0);
    check_eq("drain_done", exp_q.size(), 0);
    @(negedge clock);
    #1;
    check_eq("drain_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
